// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLTU  = 4'b0011,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULTU = 4'b1000,
    OP_DIVU  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } alu_state_t;

endpackage

// File: rtl/add_sub_nb.sv
// Shared WIDTH-bit adder/subtractor with carry out.
module add_sub_nb #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  assign bx   = sub ? ~b : b;
  assign full = {1'b0, a} + {1'b0, bx}
              + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign c_out = full[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle logic/arith, bit-serial MULTU and DIVU.
// DIVU and its state are built only when ALU_SEQ_DIV_EN is defined.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             op_err
);

  localparam int CW = $clog2(WIDTH) + 1;

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_sub, c_out;
  logic             accept, last, slt, sltu;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign op_err    = err_q;
  assign last      = (cnt_q == CW'(WIDTH - 1));

  add_sub_nb #(.WIDTH(WIDTH)) u_add (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .sum   (sum),
    .c_out (c_out)
  );

  // Adder input steering: operands in IDLE, partial product or trial subtract otherwise
  always_comb begin
    add_a   = src_a;
    add_b   = src_b;
    add_sub = (op == OP_SUB) || (op == OP_SLT)
           || (op == OP_SLTU);
    unique case (1'b1)
      (state_q == S_MUL): begin
        add_a   = hi_q;
        add_b   = a_q;
        add_sub = 1'b0;
      end
`ifdef ALU_SEQ_DIV_EN
      (state_q == S_DIV): begin
        add_a   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        add_b   = a_q;
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign slt  = (src_a[WIDTH-1] != src_b[WIDTH-1])
              ? src_a[WIDTH-1] : sum[WIDTH-1];
  assign sltu = ~c_out;

`ifdef ALU_SEQ_DIV_EN
  logic ge;
  // Shifted-out remainder MSB means the trial difference cannot go negative
  assign ge = hi_q[WIDTH-1] | c_out;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DONE;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = '0;
          zero_d  = 1'b0;
          err_d   = 1'b0;
          unique case (op)
            OP_AND:  lo_d = src_a & src_b;
            OP_OR:   lo_d = src_a | src_b;
            OP_ADD:  lo_d = sum;
            OP_SUB:  lo_d = sum;
            OP_SLT:  lo_d = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: lo_d = {{(WIDTH-1){1'b0}}, sltu};
            OP_MULTU: begin
              a_d     = src_a;
              lo_d    = src_b;
              state_d = S_MUL;
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
              if (src_b == '0) begin
                lo_d = '1;
                hi_d = src_a;
              end else begin
                a_d     = src_b;
                lo_d    = src_a;
                state_d = S_DIV;
              end
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (lo_q[0]) begin
          hi_d = {c_out, sum[WIDTH-1:1]};
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (last) state_d = S_DONE;
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        hi_d  = ge ? sum
                   : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d  = {lo_q[WIDTH-2:0], ge};
        if (last) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_DONE && state_d == S_DONE)
      zero_d = (lo_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width in bits (legal: 8..64, even).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  the request is valid.
REQ-005 The block SHALL have port in_ready  output  1  the block accepts a request.
REQ-006 The block SHALL have port op  input  4  operation code (alu_pkg::alu_op_t).
REQ-007 The block SHALL have port src_a  input  WIDTH  operand A.
REQ-008 The block SHALL have port src_b  input  WIDTH  operand B.
REQ-009 The block SHALL have port out_valid  output  1  the result is valid.
REQ-010 The block SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 The block SHALL have port result_lo  output  WIDTH  primary result / MULTU low / DIVU quotient.
REQ-012 The block SHALL have port result_hi  output  WIDTH  MULTU high / DIVU remainder; 0 for other ops.
REQ-013 The block SHALL have port zero  output  1  set when result_lo is all zeros, for every op.
REQ-014 The block SHALL have port op_err  output  1  set when the accepted op is undefined or compiled out.

Function
REQ-015 Opcodes: AND=0000, OR=0001, ADD=0010, SLTU=0011, SUB=0110, SLT=0111, MULTU=1000, DIVU=1001.
REQ-016 FSM states: IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-017 Accept = in_valid & in_ready; operands and op are registered on accept and are ignored at all other times.
REQ-018 Single-cycle ops (AND/OR/ADD/SUB/SLT/SLTU, undefined): IDLE->DONE on accept; out_valid is high on the next cycle (latency 1).
REQ-019 ADD/SUB are modulo 2^WIDTH with carry discarded; SLT is a signed compare and SLTU an unsigned compare, each giving result_lo = 1 or 0.
REQ-020 MULTU: unsigned shift-add, one bit per cycle, for WIDTH cycles in MUL; out_valid is high WIDTH+1 cycles after accept; {hi,lo} is the 2*WIDTH product.
REQ-021 DIVU: unsigned restoring divide, one bit per cycle, for WIDTH cycles in DIV, with the same latency as MULTU.
REQ-022 DIVU with src_b=0: IDLE->DONE directly (latency 1), giving result_lo=all ones, result_hi=src_a, op_err=0.
REQ-023 The iteration counter SHALL be $clog2(WIDTH)+1 bits and SHALL be cleared on accept.
REQ-024 DONE: outputs are held stable while out_valid=1 and out_ready=0; on out_valid&out_ready the FSM moves DONE->IDLE, and in_ready rises the following cycle.
REQ-025 Undefined op: result_lo=0, result_hi=0, zero=1, op_err=1, latency 1.
REQ-026 A new accept SHALL NOT occur in the same cycle as a result handoff (no bypass).

Reset
REQ-027 Asserting rst_n low SHALL, asynchronously and at any time including mid-MUL/DIV, force IDLE, abandon any in-flight operation without producing a result, and set in_ready=1, out_valid=0, result_lo=0, result_hi=0, zero=0, op_err=0, counter=0.
REQ-028 On deassertion the first accept is possible on the first rising edge after rst_n goes high.

Configuration
REQ-029 Macro ALU_SEQ_DIV_EN: when defined, DIVU and the DIV state are present; when undefined, DIVU is treated as undefined (REQ-025) and no divider logic is generated.

Structure
REQ-030 Package alu_pkg SHALL hold alu_op_t, the opcode constants, and the state enum alu_state_t.
REQ-031 Sub-module add_sub_nb (parameter WIDTH; ports a, b, sub, sum, c_out) SHALL be the single adder, shared by ADD, SUB, SLT/SLTU and the divide trial subtraction.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+1 -> result_lo=0x80000000, zero=0, out_valid 1 cycle after accept; SUB 5-5 -> result_lo=0, zero=1.
REQ-033 SLT a=0xFFFFFFFF, b=1 -> result_lo=1; SLTU with the same operands -> result_lo=0.
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-035 DIVU 100/7 -> result_lo=14, result_hi=2 at 33 cycles after accept; DIVU 9/0 -> result_lo=0xFFFFFFFF, result_hi=9 at 1 cycle after accept; with the macro undefined -> op_err=1.
REQ-036 Hold out_ready=0 for 5 cycles after out_valid rises -> outputs stable, in_ready=0; a second in_valid is ignored until IDLE.
REQ-037 Drop rst_n at cycle 10 of a MULTU -> all outputs take their reset values immediately; no out_valid appears after release.
